// File: rtl/imem_loader.sv
// imem_loader: streams 32-bit instruction words into a byte-wide instruction
// memory. The pipeline is held in reset for the whole load.
//
// Ports
//   clk          in   1   rising-edge clock
//   reset        in   1   asynchronous active-low reset
//   start        in   1   load request, accepted only in IDLE or DONE
//   word_count   in   8   number of words to load (sampled on accepted start)
//   word_valid   in   1   word_data is valid
//   word_data    in  32   instruction word, big-endian byte order
//   word_ready   out  1   loader accepts a word this cycle (WAIT_WORD only)
//   mem_we       out  1   byte write strobe
//   mem_addr     out  9   byte write address
//   mem_wdata    out  8   byte write data
//   pipe_hold    out  1   pipeline hold, high while loading
//   done         out  1   load finished, held until the next accepted start
//   err          out  1   word_count exceeded MAX_WORDS
//   words_loaded out  8   words fully written in the current or last load
module imem_loader #(
  parameter logic [8:0] BASE_ADDR = 9'd0,
  parameter int         MAX_WORDS = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  word_count,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  output logic        word_ready,
  output logic        mem_we,
  output logic [8:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        pipe_hold,
  output logic        done,
  output logic        err,
  output logic [7:0]  words_loaded
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WORD = 2'd1,
    WRITE     = 2'd2,
    DONE      = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  loaded_q, loaded_d;
  logic [1:0]  beat_q, beat_d;
  logic [31:0] word_q, word_d;
  logic        err_q, err_d;

  logic        start_acc_s;
  logic        zero_s;
  logic        over_s;
  logic        last_beat_s;
  logic        last_word_s;
  logic [7:0]  loaded_inc_s;

  // start is only honoured when no load is in progress
  assign start_acc_s  = start & ((state_q == IDLE) | (state_q == DONE));
  assign zero_s       = (word_count == 8'd0);
  assign over_s       = ({24'd0, word_count} > 32'(MAX_WORDS));
  assign last_beat_s  = (beat_q == 2'd3);
  assign loaded_inc_s = loaded_q + 8'd1;
  assign last_word_s  = (loaded_inc_s == count_q);

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= 8'd0;
      loaded_q <= 8'd0;
      beat_q   <= 2'd0;
      word_q   <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      loaded_q <= loaded_d;
      beat_q   <= beat_d;
      word_q   <= word_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Empty or oversized loads finish immediately without writing
          if (zero_s || over_s) begin
            state_d = DONE;
          end else begin
            state_d = WAIT_WORD;
          end
        end else begin
          state_d = state_q;
        end
      end
      WAIT_WORD: begin
        if (word_valid) begin
          state_d = WRITE;
        end else begin
          state_d = WAIT_WORD;
        end
      end
      WRITE: begin
        if (last_beat_s) begin
          state_d = last_word_s ? DONE : WAIT_WORD;
        end else begin
          state_d = WRITE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: count/word capture, beat and word counters, error flag
  always_comb begin
    count_d  = count_q;
    loaded_d = loaded_q;
    beat_d   = beat_q;
    word_d   = word_q;
    err_d    = err_q;
    if (start_acc_s) begin
      loaded_d = 8'd0;
      err_d    = over_s;
      beat_d   = 2'd0;
      if (!zero_s && !over_s) begin
        count_d = word_count;
      end else begin
        count_d = count_q;
      end
    end else if ((state_q == WAIT_WORD) && word_valid) begin
      word_d = word_data;
      beat_d = 2'd0;
    end else if (state_q == WRITE) begin
      beat_d = beat_q + 2'd1;
      if (last_beat_s) begin
        loaded_d = loaded_inc_s;
      end else begin
        loaded_d = loaded_q;
      end
    end else begin
      beat_d = beat_q;
    end
  end

  // Outputs decoded from state; byte lanes are big-endian
  always_comb begin
    word_ready = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 9'd0;
    mem_wdata  = 8'd0;
    pipe_hold  = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        done = 1'b0;
      end
      WAIT_WORD: begin
        word_ready = 1'b1;
        pipe_hold  = 1'b1;
      end
      WRITE: begin
        pipe_hold = 1'b1;
        mem_we    = 1'b1;
        // Only the low 7 bits of the word index matter: 4*128 wraps to 0 mod 512
        mem_addr  = BASE_ADDR + {loaded_q[6:0], 2'b00} + {7'd0, beat_q};
        case (beat_q)
          2'd0:    mem_wdata = word_q[31:24];
          2'd1:    mem_wdata = word_q[23:16];
          2'd2:    mem_wdata = word_q[15:8];
          2'd3:    mem_wdata = word_q[7:0];
          default: mem_wdata = 8'd0;
        endcase
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        done = 1'b0;
      end
    endcase
  end

  assign err          = err_q;
  assign words_loaded = loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  word_count = 8'd0;
  logic        word_valid = 1'b0;
  logic [31:0] word_data = 32'd0;
  logic        word_ready;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        pipe_hold;
  logic        done;
  logic        err;
  logic [7:0]  words_loaded;

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .pipe_hold(pipe_hold), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [8:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Expected bytes of word idx (BASE_ADDR = 0), big-endian
  task automatic push_word(input int idx, input logic [31:0] data);
    wr_t e;
    for (int b = 0; b < 4; b++) begin
      e.a = 9'(4 * idx + b);
      e.d = data[31 - 8*b -: 8];
      exp_q.push_back(e);
    end
  endtask

  // Scoreboard monitor: every observed byte write is matched against the queue
  always @(negedge clk) begin
    if (reset && mem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=%0h data=%0h", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", {23'd0, mem_addr}, {23'd0, mon_e.a});
        chk("wr_data", {24'd0, mem_wdata}, {24'd0, mon_e.d});
      end
    end
  end

  task automatic do_start(input logic [7:0] cnt);
    @(posedge clk); #1;
    start = 1'b1;
    word_count = cnt;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input int idx, input logic [31:0] data);
    int n;
    push_word(idx, data);
    word_valid = 1'b1;
    word_data = data;
    n = 0;
    while (!word_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("word_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    word_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_word_ready"}, {31'd0, word_ready}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, {23'd0, mem_addr}, 32'd0);
    chk({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
    chk({tag, "_pipe_hold"}, {31'd0, pipe_hold}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_words_loaded"}, {24'd0, words_loaded}, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", {31'd0, word_ready}, 32'd0);

    // Two-word load
    do_start(8'd2);
    chk("load_hold", {31'd0, pipe_hold}, 32'd1);
    send_word(0, 32'h8C010004);
    send_word(1, 32'h00221820);
    @(negedge clk);
    chk("load2_done", {31'd0, done}, 32'd1);
    chk("load2_loaded", {24'd0, words_loaded}, 32'd2);
    chk("load2_hold", {31'd0, pipe_hold}, 32'd0);
    chk("load2_err", {31'd0, err}, 32'd0);

    // Oversized count
    do_start(8'd129);
    chk("over_hold", {31'd0, pipe_hold}, 32'd0);
    @(negedge clk);
    chk("over_err", {31'd0, err}, 32'd1);
    chk("over_done", {31'd0, done}, 32'd1);
    chk("over_loaded", {24'd0, words_loaded}, 32'd0);

    // Zero count
    do_start(8'd0);
    @(negedge clk);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_err", {31'd0, err}, 32'd0);
    chk("zero_hold", {31'd0, pipe_hold}, 32'd0);

    // Delayed word_valid
    do_start(8'd1);
    repeat (3) begin
      @(negedge clk);
      chk("delay_ready", {31'd0, word_ready}, 32'd1);
      chk("delay_we", {31'd0, mem_we}, 32'd0);
    end
    push_word(0, 32'h12345678);
    word_valid = 1'b1;
    word_data = 32'h12345678;
    @(posedge clk); #1;
    word_valid = 1'b0;
    chk("delay_first_we", {31'd0, mem_we}, 32'd1);
    chk("delay_first_ready", {31'd0, word_ready}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("delay_done", {31'd0, done}, 32'd1);
    chk("delay_loaded", {24'd0, words_loaded}, 32'd1);

    // start pulsed during WRITE is ignored
    do_start(8'd2);
    push_word(0, 32'hDEADBEEF);
    word_valid = 1'b1;
    word_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    word_valid = 1'b0;
    start = 1'b1;
    word_count = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("ign_loaded", {24'd0, words_loaded}, 32'd1);
    chk("ign_hold", {31'd0, pipe_hold}, 32'd1);
    chk("ign_done", {31'd0, done}, 32'd0);
    send_word(1, 32'h01020304);
    chk("ign_final_done", {31'd0, done}, 32'd1);
    chk("ign_final_loaded", {24'd0, words_loaded}, 32'd2);

    // Restart from DONE goes back to BASE_ADDR
    do_start(8'd1);
    chk("restart_done", {31'd0, done}, 32'd0);
    chk("restart_loaded", {24'd0, words_loaded}, 32'd0);
    send_word(0, 32'hCAFEF00D);
    chk("restart_final_done", {31'd0, done}, 32'd1);

    // Reset during beat 2: only beats 0 and 1 observed
    do_start(8'd1);
    push_word(0, 32'hAABBCCDD);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    word_valid = 1'b1;
    word_data = 32'hAABBCCDD;
    @(posedge clk); #1;
    word_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_ready", {31'd0, word_ready}, 32'd0);
      chk("post_rst_hold", {31'd0, pipe_hold}, 32'd0);
      chk("post_rst_done", {31'd0, done}, 32'd0);
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 9'd0: byte address of the first instruction written.
REQ-002 Parameter MAX_WORDS, default 128: instruction-memory capacity in 32-bit words (512 bytes).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 start  input  1  one-cycle load request; sampled only in IDLE or DONE.
REQ-006 word_count  input  8  number of words to load; sampled on accepted start.
REQ-007 word_valid  input  1  word_data holds a valid instruction word.
REQ-008 word_data  input  32  instruction word, big-endian (bits 31:24 go to the lowest address).
REQ-009 word_ready  output  1  loader can accept a word this cycle.
REQ-010 mem_we  output  1  byte write strobe to the instruction-memory byte array.
REQ-011 mem_addr  output  9  byte write address.
REQ-012 mem_wdata  output  8  byte write data.
REQ-013 pipe_hold  output  1  high while loading; the pipeline is held in reset while it is high.
REQ-014 done  output  1  load finished; held until the next accepted start.
REQ-015 err  output  1  word_count exceeded MAX_WORDS; held until the next accepted start.
REQ-016 words_loaded  output  8  count of words fully written in the current or last load.

Function
REQ-017 FSM states SHALL be IDLE, WAIT_WORD, WRITE and DONE.
REQ-018 IDLE/DONE + start: if word_count == 0 -> DONE next cycle; done=1, err=0, no writes.
REQ-019 IDLE/DONE + start: if word_count > MAX_WORDS -> DONE next cycle; err=1, done=1, no writes.
REQ-020 IDLE/DONE + start, otherwise:
- latch word_count
- clear words_loaded, done and err
- go to WAIT_WORD
REQ-021 pipe_hold SHALL be 1 exactly in WAIT_WORD and WRITE.
REQ-022 word_ready SHALL be 1 only in WAIT_WORD; it is combinational from state only, never from word_valid.
REQ-023 Transfer occurs on a rising edge with word_valid & word_ready: capture word_data, beat=0, go to WRITE.
REQ-024 WRITE SHALL last exactly 4 cycles, beats 0..3, with mem_we=1 each cycle.
REQ-025 In WRITE, mem_addr SHALL equal BASE_ADDR + 4*words_loaded + beat, modulo 512.
REQ-026 mem_wdata SHALL be word[31:24], [23:16], [15:8], [7:0] for beats 0..3 respectively.
REQ-027 On the beat-3 edge, words_loaded increments; if the new value equals the latched count -> DONE, else -> WAIT_WORD.
REQ-028 Throughput SHALL be at most one word per 5 cycles: 1 accept cycle + 4 write cycles.
REQ-029 Outside WRITE, mem_we SHALL be 0; mem_addr and mem_wdata SHALL be 0.
REQ-030 start in WAIT_WORD or WRITE SHALL be ignored, with no effect on state or counters.
REQ-031 word_valid outside WAIT_WORD SHALL be ignored; the word is not consumed.
REQ-032 Address overflow past byte 511 SHALL wrap; REQ-019 prevents wrap when BASE_ADDR=0.

Reset
REQ-033 reset=0 SHALL immediately force:
- state=IDLE
- word_ready=0, mem_we=0, mem_addr=0, mem_wdata=0
- pipe_hold=0, done=0, err=0, words_loaded=0
REQ-034 reset asserted mid-WRITE SHALL abort the load; bytes already written stay in memory and no further write occurs.
REQ-035 After reset deasserts, the block SHALL stay in IDLE until start.

Verification
REQ-036 start, word_count=2; words 0x8C010004 then 0x00221820 -> writes:
- bytes 8C,01,00,04 to addresses 0..3
- bytes 00,22,18,20 to addresses 4..7
- then done=1, words_loaded=2, pipe_hold=0
REQ-037 start, word_count=0 -> done=1 one cycle later; mem_we never asserted; err=0.
REQ-038 start, word_count=129 -> err=1 and done=1 one cycle later; no writes; pipe_hold never 1.
REQ-039 word_valid delayed 3 cycles in WAIT_WORD -> word_ready stays 1, mem_we stays 0, and writing begins the cycle after the transfer.
REQ-040 reset=0 during beat 2 of word 0 -> all outputs at reset values immediately; only addresses 0..1 (plus beat 2 if its edge has already occurred) are written.
REQ-041 start pulsed during WRITE -> ignored; the load completes with the original count; a later start in DONE clears done and restarts at BASE_ADDR.
